sdram_arbiter: RTL

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/tecmo_pkg.sv | 15 +
 rtl/rr_select.sv | 31 +++
 rtl/sdram_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/tecmo_pkg.sv
// Shared definitions for the tecmo SDRAM front end: arbiter state encoding and
// default bus widths.
package tecmo_pkg;

    localparam int unsigned DEF_NUM_PORTS  = 4;
    localparam int unsigned DEF_ADDR_WIDTH = 23;
    localparam int unsigned DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_ACK   = 2'd1,
        WAIT_VALID = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// Round-robin picker: first set request at or after ptr, ascending with wrap.
module rr_select #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0] cand;

    // Walk candidates from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (IW + 1)'(i);
            if (cand >= (IW + 1)'(N)) begin
                cand = cand - (IW + 1)'(N);
            end
            if (req[cand[IW-1:0]]) begin
                idx = cand[IW-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates ROM download writes and round-robin client reads onto a single
// SDRAM controller port, one transaction outstanding at a time.
module sdram_arbiter
    import tecmo_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = DEF_NUM_PORTS,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            download,
    input  logic                            dl_req,
    input  logic [ADDR_WIDTH-1:0]           dl_addr,
    input  logic [DATA_WIDTH-1:0]           dl_data,
    output logic                            dl_ack,
    input  logic [NUM_PORTS-1:0]            rd_req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_PORTS-1:0]            rd_ack,
    output logic [NUM_PORTS-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]           rd_q,
    output logic [ADDR_WIDTH-1:0]           sdram_addr,
    output logic [DATA_WIDTH-1:0]           sdram_data,
    output logic                            sdram_we,
    output logic                            sdram_req,
    input  logic                            sdram_ack,
    input  logic                            sdram_valid,
    input  logic [DATA_WIDTH-1:0]           sdram_q
);

    localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_t            state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [PW-1:0]         gnt_q, gnt_d;
    logic [PW-1:0]         sel_idx;
    logic                  sel_any;
    logic [PW:0]           ptr_inc;
    logic                  settling;
    logic [ADDR_WIDTH-1:0] port_addr [NUM_PORTS];

    logic                  req_d;
    logic                  we_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] rd_q_d;
    logic                  dl_ack_d;
    logic [NUM_PORTS-1:0]  rd_ack_d;
    logic [NUM_PORTS-1:0]  rd_valid_d;

    rr_select #(
        .N (NUM_PORTS)
    ) u_rr_select (
        .req (rd_req),
        .ptr (ptr_q),
        .idx (sel_idx),
        .any (sel_any)
    );

    always_comb begin
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            port_addr[p] = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // A completion pulse is visible to requesters this cycle; their request
    // lines still reflect the finished transaction, so hold off granting.
    assign settling = dl_ack | (|rd_ack) | (|rd_valid);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        req_d      = sdram_req;
        we_d       = sdram_we;
        addr_d     = sdram_addr;
        data_d     = sdram_data;
        rd_q_d     = rd_q;
        dl_ack_d   = 1'b0;
        rd_ack_d   = '0;
        rd_valid_d = '0;

        ptr_inc = {1'b0, sel_idx} + (PW + 1)'(1);
        if (ptr_inc >= (PW + 1)'(NUM_PORTS)) begin
            ptr_inc = '0;
        end

        case (state_q)
            IDLE: begin
                if (!settling) begin
                    if (download) begin
                        if (dl_req) begin
                            addr_d  = dl_addr;
                            data_d  = dl_data;
                            we_d    = 1'b1;
                            req_d   = 1'b1;
                            state_d = WAIT_ACK;
                        end
                    end else if (sel_any) begin
                        gnt_d   = sel_idx;
                        addr_d  = port_addr[sel_idx];
                        we_d    = 1'b0;
                        req_d   = 1'b1;
                        ptr_d   = ptr_inc[PW-1:0];
                        state_d = WAIT_ACK;
                    end
                end
            end

            WAIT_ACK: begin
                if (sdram_ack) begin
                    req_d = 1'b0;
                    if (sdram_we) begin
                        dl_ack_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        rd_ack_d[gnt_q] = 1'b1;
                        if (sdram_valid) begin
                            rd_valid_d[gnt_q] = 1'b1;
                            rd_q_d            = sdram_q;
                            state_d           = IDLE;
                        end else begin
                            state_d = WAIT_VALID;
                        end
                    end
                end
            end

            WAIT_VALID: begin
                if (sdram_valid) begin
                    rd_valid_d[gnt_q] = 1'b1;
                    rd_q_d            = sdram_q;
                    state_d           = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            sdram_req  <= 1'b0;
            sdram_we   <= 1'b0;
            sdram_addr <= '0;
            sdram_data <= '0;
            rd_q       <= '0;
            dl_ack     <= 1'b0;
            rd_ack     <= '0;
            rd_valid   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            sdram_req  <= req_d;
            sdram_we   <= we_d;
            sdram_addr <= addr_d;
            sdram_data <= data_d;
            rd_q       <= rd_q_d;
            dl_ack     <= dl_ack_d;
            rd_ack     <= rd_ack_d;
            rd_valid   <= rd_valid_d;
        end
    end

endmodule
